// File: rtl/mux_2to1_rr.sv
// Two-lane recombiner: each lane feeds a small FIFO, and a round-robin
// arbiter (lane 1 first) drains them into one registered word stream.
module mux_2to1_rr #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              valid_in1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full0,
    output logic              full1,
    output logic              empty0,
    output logic              empty1,
    output logic              overflow
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [PTR_W-1:0]  wr_ptr0, rd_ptr0;
    logic [PTR_W-1:0]  wr_ptr1, rd_ptr1;
    logic [PTR_W:0]    count0, count1;
    logic              sel, sel_next;
    logic              pop0, pop1;
    logic              push0, push1;
    logic              avail0, avail1;

    assign avail0 = (count0 != '0);
    assign avail1 = (count1 != '0);

    // A full lane still accepts a word when it is popped in the same cycle
    assign push0 = valid_in0 && (count0 != CNT_FULL || pop0);
    assign push1 = valid_in1 && (count1 != CNT_FULL || pop1);

    assign full0  = (count0 == CNT_FULL);
    assign full1  = (count1 == CNT_FULL);
    assign empty0 = !avail0;
    assign empty1 = !avail1;

    // sel names the lane owed the next turn
    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= 1'b1;
        end else begin
            sel <= sel_next;
        end
    end

    // A lane popped out of turn does not consume the owed turn
    always_comb begin
        sel_next = sel;
        if (sel && avail1) begin
            sel_next = 1'b0;
        end else if (!sel && avail0) begin
            sel_next = 1'b1;
        end
    end

    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (sel ? avail1 : avail0) begin
            pop1 = sel;
            pop0 = !sel;
        end else if (sel ? avail0 : avail1) begin
            pop0 = sel;
            pop1 = !sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr0 <= '0;
            rd_ptr0 <= '0;
            count0  <= '0;
            wr_ptr1 <= '0;
            rd_ptr1 <= '0;
            count1  <= '0;
        end else begin
            if (push0) wr_ptr0 <= wr_ptr0 + PTR_ONE;
            if (pop0)  rd_ptr0 <= rd_ptr0 + PTR_ONE;
            if (push0 && !pop0) count0 <= count0 + CNT_ONE;
            if (!push0 && pop0) count0 <= count0 - CNT_ONE;
            if (push1) wr_ptr1 <= wr_ptr1 + PTR_ONE;
            if (pop1)  rd_ptr1 <= rd_ptr1 + PTR_ONE;
            if (push1 && !pop1) count1 <= count1 + CNT_ONE;
            if (!push1 && pop1) count1 <= count1 - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push0) mem0[wr_ptr0] <= data_in0;
        if (!reset && push1) mem1[wr_ptr1] <= data_in1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            valid_out <= pop0 || pop1;
            if (pop0) begin
                data_out <= mem0[rd_ptr0];
            end else if (pop1) begin
                data_out <= mem1[rd_ptr1];
            end else begin
                data_out <= '0;
            end
            if ((valid_in0 && !push0) || (valid_in1 && !push1)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_2to1_rr.sv
// Bench for mux_2to1_rr: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_mux_2to1_rr;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [3:0] data_in0;
    logic       valid_in0;
    logic [3:0] data_in1;
    logic       valid_in1;
    logic [3:0] data_out;
    logic       valid_out;
    logic       full0;
    logic       full1;
    logic       empty0;
    logic       empty1;
    logic       overflow;

    mux_2to1_rr #(
        .DATA_W(4),
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in0 (data_in0),
        .valid_in0(valid_in0),
        .data_in1 (data_in1),
        .valid_in1(valid_in1),
        .data_out (data_out),
        .valid_out(valid_out),
        .full0    (full0),
        .full1    (full1),
        .empty0   (empty0),
        .empty1   (empty1),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
        logic       ev;
        logic [3:0] ed;
        logic       ee0;
        logic       ee1;
        logic       eovf;
    } vec_t;

    vec_t tbl[$];

    // Reference model: two word queues plus the owed-turn lane
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic       m_turn;
    logic       m_valid;
    logic [3:0] m_data;
    logic       m_ovf;

    function automatic vec_t mk(
        input int rst, input int v0, input int d0,
        input int v1, input int d1, input int ev,
        input int ed, input int e0, input int e1,
        input int ov
    );
        vec_t v;
        v.rst  = 1'(rst);
        v.v0   = 1'(v0);
        v.d0   = 4'(d0);
        v.v1   = 1'(v1);
        v.d1   = 4'(d1);
        v.ev   = 1'(ev);
        v.ed   = 4'(ed);
        v.ee0  = 1'(e0);
        v.ee1  = 1'(e1);
        v.eovf = 1'(ov);
        return v;
    endfunction

    task automatic check(
        input string name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic model_step(
        input logic r, input logic v0, input logic [3:0] d0,
        input logic v1, input logic [3:0] d1
    );
        if (r) begin
            q0.delete();
            q1.delete();
            m_turn  = 1'b1;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_data  = 4'h0;
        end else begin
            m_valid = 1'b0;
            m_data  = 4'h0;
            if (m_turn && q1.size() > 0) begin
                m_data  = q1.pop_front();
                m_valid = 1'b1;
                m_turn  = 1'b0;
            end else if (!m_turn && q0.size() > 0) begin
                m_data  = q0.pop_front();
                m_valid = 1'b1;
                m_turn  = 1'b1;
            end else if (q0.size() > 0) begin
                m_data  = q0.pop_front();
                m_valid = 1'b1;
            end else if (q1.size() > 0) begin
                m_data  = q1.pop_front();
                m_valid = 1'b1;
            end
            if (v0) begin
                if (q0.size() < DEPTH) q0.push_back(d0);
                else m_ovf = 1'b1;
            end
            if (v1) begin
                if (q1.size() < DEPTH) q1.push_back(d1);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle(
        input logic r, input logic v0, input logic [3:0] d0,
        input logic v1, input logic [3:0] d1
    );
        reset     = r;
        valid_in0 = v0;
        data_in0  = d0;
        valid_in1 = v1;
        data_in1  = d1;
        @(posedge clk);
        model_step(r, v0, d0, v1, d1);
        #1;
    endtask

    function automatic logic [9:0] dut_vec();
        return {valid_out, data_out, full0, full1,
                empty0, empty1, overflow};
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_valid, m_data,
                q0.size() == DEPTH, q1.size() == DEPTH,
                q0.size() == 0, q1.size() == 0, m_ovf};
    endfunction

    task automatic check_model(input string name);
        check(name, 32'(dut_vec()), 32'(model_vec()));
    endtask

    initial begin
        logic [3:0] got[$];
        int f0_at;
        int f1_at;
        int p0;
        int p1;

        reset     = 1'b1;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        data_in0  = 4'h0;
        data_in1  = 4'h0;
        m_turn    = 1'b1;
        m_valid   = 1'b0;
        m_data    = 4'h0;
        m_ovf     = 1'b0;

        // rst v0 d0 v1 d1 | ev ed e0 e1 ovf
        tbl.push_back(mk(1, 1, 15, 1, 15, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 15, 1, 15, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 10, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 11, 0, 0, 1, 10, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 12, 1, 11, 1, 0, 0));
        tbl.push_back(mk(0, 1, 13, 0, 0, 1, 12, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 13, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5, 0, 0, 1, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 1, 1, 0));
        tbl.push_back(mk(0, 1, 9, 1, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].v0, tbl[i].d0,
                  tbl[i].v1, tbl[i].d1);
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({tbl[i].ev, tbl[i].ed, 1'b0, 1'b0,
                       tbl[i].ee0, tbl[i].ee1, tbl[i].eovf}));
        end

        // Wrap-around: 10 words alternating, lane 1 first
        for (int i = 0; i < 12; i++) begin
            if (i >= 10) cycle(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
            else if (i % 2 == 0) cycle(1'b0, 1'b0, 4'h0, 1'b1, 4'(i));
            else cycle(1'b0, 1'b1, 4'(i), 1'b0, 4'h0);
            check_model($sformatf("wrap_c%0d", i));
            if (valid_out) got.push_back(data_out);
        end
        check("wrap_count", 32'(got.size()), 32'd10);
        foreach (got[i]) check($sformatf("wrap_w%0d", i),
                               32'(got[i]), 32'(i));
        check("wrap_empty", 32'({empty0, empty1}), 32'h3);
        check("wrap_ovf", 32'(overflow), 32'h0);

        // Overflow under sustained dual-lane input
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        f0_at = 0;
        f1_at = 0;
        for (int k = 1; k <= 15; k++) begin
            cycle(1'b0, 1'b1, 4'(k), 1'b1, 4'(k));
            check_model($sformatf("ovf_c%0d", k));
            if (full0 && f0_at == 0) f0_at = k;
            if (full1 && f1_at == 0) f1_at = k;
        end
        check("full0_time",
              32'(f0_at != 0 && f0_at - 1 <= DEPTH + 2), 32'h1);
        check("full1_time",
              32'(f1_at != 0 && f1_at - 1 <= DEPTH + 2), 32'h1);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
            check_model($sformatf("drain_c%0d", k));
        end
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Reset with words still buffered
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        check("rst_ovf_clr", 32'(overflow), 32'h0);
        cycle(1'b0, 1'b1, 4'h4, 1'b1, 4'h1);
        cycle(1'b0, 1'b1, 4'h5, 1'b1, 4'h2);
        cycle(1'b0, 1'b1, 4'h6, 1'b1, 4'h3);
        check("pre_rst_nonempty", 32'(empty1), 32'h0);
        cycle(1'b1, 1'b1, 4'h8, 1'b1, 4'h6);
        check("mid_rst_valid", 32'(valid_out), 32'h0);
        check("mid_rst_empty1", 32'(empty1), 32'h1);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 4'hE);
        check("mid_rst_quiet", 32'(valid_out), 32'h0);
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        check("mid_rst_first", 32'({valid_out, data_out}),
              32'h1E);
        check_model("mid_rst_model");

        // Randomized traffic with occasional resets
        for (int b = 0; b < 5; b++) begin
            p0 = $urandom_range(10, 100);
            p1 = $urandom_range(10, 100);
            for (int k = 0; k < 100; k++) begin
                cycle($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < p0,
                      4'($urandom()),
                      $urandom_range(0, 99) < p1,
                      4'($urandom()));
                check_model($sformatf("rnd_b%0d_c%0d", b, k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
